// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, registered {cout,sum}.
// Optional subtract mode (sub port, B inverted, carry forced to 1) under SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             s_bit, c_bit, last_bit;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_bit    = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign last_bit = (cnt_q == LastBit);
  // Shift the new sum bit in at the MSB end; written as shifts so WIDTH=1 stays legal.
  assign res_shift = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StRun:   busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == StIdle && start) begin
      a_d     = a;
      b_d     = b_load;
      carry_d = c_load;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = res_shift;
      carry_d = c_bit;
      cnt_d   = last_bit ? '0 : cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d  = res_shift;
        cout_d = c_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule
